// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes and a registered result.
// RV32I ops finish in one cycle. RV32M multiply/divide are iterative, one bit
// per cycle, and are present only when ALU_MC_MULDIV_EN is defined. Without
// that macro, M-op codes are reported as illegal ops.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] AluA,
  input  logic [WIDTH-1:0] AluB,
  input  logic [4:0]       AluOp,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] AluRes,
  output logic             IllegalOp
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             illegal_r;
  logic [WIDTH-1:0] res_r;

  logic [WIDTH-1:0] single_res_s;
  logic             single_ok_s;
  logic [SHW-1:0]   shamt_s;

  assign shamt_s   = AluB[SHW-1:0];
  assign InReady   = in_ready_r;
  assign OutValid  = out_valid_r;
  assign AluRes    = res_r;
  assign IllegalOp = illegal_r;

  // Single-cycle RV32I result from the operands presented at accept.
  always_comb begin
    single_res_s = {WIDTH{1'b0}};
    single_ok_s  = 1'b1;
    case (AluOp)
      5'b00000: single_res_s = AluA + AluB;
      5'b01000: single_res_s = AluA - AluB;
      5'b00100: single_res_s = AluA ^ AluB;
      5'b00110: single_res_s = AluA | AluB;
      5'b00111: single_res_s = AluA & AluB;
      5'b00001: single_res_s = AluA << shamt_s;
      5'b00101: single_res_s = AluA >> shamt_s;
      5'b01101: single_res_s = $unsigned($signed(AluA) >>> shamt_s);
      5'b00010: single_res_s = {{(WIDTH-1){1'b0}}, ($signed(AluA) < $signed(AluB))};
      5'b00011: single_res_s = {{(WIDTH-1){1'b0}}, (AluA < AluB)};
      default: begin
        single_res_s = {WIDTH{1'b0}};
        single_ok_s  = 1'b0;
      end
    endcase
  end

`ifdef ALU_MC_MULDIV_EN
  // Iterative datapath: acc/q form {high,low} of the product or {remainder,
  // quotient}; d holds the multiplicand or divisor magnitude.
  logic             is_md_s;
  logic [SHW-1:0]   cnt_r;
  logic             setup_r;
  logic [2:0]       mop_r;
  logic [WIDTH-1:0] a_r, b_r, acc_r, q_r, d_r;
  logic             neg_r, neg_rem_r, bzero_r;

  logic             sgn_a_s, sgn_b_s, neg_a_s, neg_b_s;
  logic [WIDTH-1:0] mag_a_s, mag_b_s;
  logic [WIDTH:0]   sum_s, rem_sh_s;
  logic             ge_s;
  logic [WIDTH-1:0] diff_s, n_acc_s, n_q_s, fin_s;
  logic [2*WIDTH-1:0] prod_mag_s, prod_s;

  assign is_md_s = (AluOp[4:3] == 2'b10);

  // Operand signedness and magnitudes, used in the setup cycle.
  always_comb begin
    sgn_a_s = (mop_r == 3'b001) || (mop_r == 3'b010) || (mop_r == 3'b100) || (mop_r == 3'b110);
    sgn_b_s = (mop_r == 3'b001) || (mop_r == 3'b100) || (mop_r == 3'b110);
    neg_a_s = sgn_a_s & a_r[WIDTH-1];
    neg_b_s = sgn_b_s & b_r[WIDTH-1];
    mag_a_s = neg_a_s ? (-a_r) : a_r;
    mag_b_s = neg_b_s ? (-b_r) : b_r;
  end

  // One shift-add (multiply) or restoring-subtract (divide) step.
  always_comb begin
    sum_s    = {1'b0, acc_r} + (q_r[0] ? {1'b0, d_r} : {(WIDTH+1){1'b0}});
    rem_sh_s = {acc_r, q_r[WIDTH-1]};
    ge_s     = (rem_sh_s >= {1'b0, d_r});
    diff_s   = rem_sh_s[WIDTH-1:0] - d_r;
    if (mop_r[2]) begin
      if (ge_s) begin
        n_acc_s = diff_s;
        n_q_s   = {q_r[WIDTH-2:0], 1'b1};
      end else begin
        n_acc_s = rem_sh_s[WIDTH-1:0];
        n_q_s   = {q_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      n_acc_s = sum_s[WIDTH:1];
      n_q_s   = {sum_s[0], q_r[WIDTH-1:1]};
    end
  end

  // Sign fix-up and corner cases applied to the final step's values.
  always_comb begin
    prod_mag_s = {n_acc_s, n_q_s};
    prod_s     = neg_r ? (-prod_mag_s) : prod_mag_s;
    case (mop_r)
      3'b000:  fin_s = prod_s[WIDTH-1:0];
      3'b001,
      3'b010,
      3'b011:  fin_s = prod_s[2*WIDTH-1:WIDTH];
      3'b100:  fin_s = bzero_r ? {WIDTH{1'b1}} : (neg_r ? (-n_q_s) : n_q_s);
      3'b101:  fin_s = bzero_r ? {WIDTH{1'b1}} : n_q_s;
      3'b110:  fin_s = bzero_r ? a_r : (neg_rem_r ? (-n_acc_s) : n_acc_s);
      3'b111:  fin_s = bzero_r ? a_r : n_acc_s;
      default: fin_s = {WIDTH{1'b0}};
    endcase
  end
`endif

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      illegal_r   <= 1'b0;
      res_r       <= {WIDTH{1'b0}};
`ifdef ALU_MC_MULDIV_EN
      cnt_r       <= {SHW{1'b0}};
      setup_r     <= 1'b0;
      mop_r       <= 3'b000;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      q_r         <= {WIDTH{1'b0}};
      d_r         <= {WIDTH{1'b0}};
      neg_r       <= 1'b0;
      neg_rem_r   <= 1'b0;
      bzero_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (InValid) begin
            in_ready_r <= 1'b0;
`ifdef ALU_MC_MULDIV_EN
            if (is_md_s) begin
              a_r     <= AluA;
              b_r     <= AluB;
              mop_r   <= AluOp[2:0];
              setup_r <= 1'b1;
              cnt_r   <= {SHW{1'b0}};
              state_r <= BUSY;
            end else
`endif
            begin
              res_r       <= single_ok_s ? single_res_s : {WIDTH{1'b0}};
              illegal_r   <= ~single_ok_s;
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end
          end
        end
`ifdef ALU_MC_MULDIV_EN
        BUSY: begin
          if (setup_r) begin
            setup_r   <= 1'b0;
            q_r       <= mag_a_s;
            d_r       <= mag_b_s;
            acc_r     <= {WIDTH{1'b0}};
            neg_r     <= neg_a_s ^ neg_b_s;
            neg_rem_r <= neg_a_s;
            bzero_r   <= (b_r == {WIDTH{1'b0}});
          end else begin
            acc_r <= n_acc_s;
            q_r   <= n_q_s;
            if (cnt_r == SHW'(WIDTH - 1)) begin
              res_r       <= fin_s;
              illegal_r   <= 1'b0;
              out_valid_r <= 1'b1;
              cnt_r       <= {SHW{1'b0}};
              state_r     <= DONE;
            end else begin
              cnt_r <= cnt_r + SHW'(1);
            end
          end
        end
`endif
        DONE: begin
          if (OutReady) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end
endmodule
